comb_event_tracker: RTL and testbench

COMB_EVENT_TRACKER -- requirements
Module: comb_event_tracker

---
 rtl/comb_event_tracker.sv | 89 ++++++++
 tb/tb_comb_event_tracker.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comb_event_tracker.sv
// comb_event_tracker: windowed rising-edge and coincidence counter for two comb_logic outputs
module comb_event_tracker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Y1,
    input  logic             Y2,
    input  logic             start,
    input  logic [7:0]       win_len,
    input  logic             clr,
    output logic             busy,
    output logic [CNT_W-1:0] rise1_cnt,
    output logic [CNT_W-1:0] rise2_cnt,
    output logic [CNT_W-1:0] both_cnt,
    output logic             res_valid,
    input  logic             res_ready
);
    typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t           state, state_nxt;
    logic             y1_prev, y2_prev;
    logic [7:0]       rem, rem_nxt;
    logic [CNT_W-1:0] rise1_nxt, rise2_nxt, both_nxt;
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && c != CNT_MAX) ? c + CNT_W'(1) : c;
    endfunction
    assign busy      = state != IDLE;
    assign res_valid = state == REPORT;
    // previous-sample registers feed edge detection and run in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y1_prev <= 1'b0;
            y2_prev <= 1'b0;
        end else begin
            y1_prev <= Y1;
            y2_prev <= Y2;
        end
    end
    // next state and counter updates; clr overrides everything else
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        rise1_nxt = rise1_cnt;
        rise2_nxt = rise2_cnt;
        both_nxt  = both_cnt;
        case (state)
            IDLE: if (start) begin
                rem_nxt   = win_len;
                rise1_nxt = '0;
                rise2_nxt = '0;
                both_nxt  = '0;
                state_nxt = (win_len == 8'd0) ? REPORT : RUN;
            end
            RUN: begin
                rise1_nxt = sat_inc(rise1_cnt, Y1 & ~y1_prev);
                rise2_nxt = sat_inc(rise2_cnt, Y2 & ~y2_prev);
                both_nxt  = sat_inc(both_cnt, Y1 & Y2);
                rem_nxt   = rem - 8'd1;
                state_nxt = (rem == 8'd1) ? REPORT : RUN;
            end
            REPORT: state_nxt = res_ready ? IDLE : REPORT;
            default: state_nxt = IDLE;
        endcase
        if (clr) begin
            state_nxt = IDLE;
            rem_nxt   = 8'd0;
            rise1_nxt = '0;
            rise2_nxt = '0;
            both_nxt  = '0;
        end
    end
    // state, remaining-sample count and result counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rem       <= 8'd0;
            rise1_cnt <= '0;
            rise2_cnt <= '0;
            both_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            rem       <= rem_nxt;
            rise1_cnt <= rise1_nxt;
            rise2_cnt <= rise2_nxt;
            both_cnt  <= both_nxt;
        end
    end
endmodule

// File: tb/tb_comb_event_tracker.sv
// tb_comb_event_tracker: randomized self-checking bench for comb_event_tracker
module tb_comb_event_tracker;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       Y1 = 1'b0, Y2 = 1'b0, start = 1'b0, clr = 1'b0, res_ready = 1'b0;
    logic [7:0] win_len = 8'd0;
    logic       busy_a, rv_a, busy_b, rv_b;
    logic [7:0] r1_a, r2_a, bc_a;
    logic [1:0] r1_b, r2_b, bc_b;
    int         n_checks = 0;
    int         n_fail = 0;
    bit         q1[$], q2[$];
    logic [23:0] exp_a;
    logic [5:0]  exp_b;

    comb_event_tracker dut_a (
        .clk(clk), .rst_n(rst_n), .Y1(Y1), .Y2(Y2), .start(start), .win_len(win_len),
        .clr(clr), .busy(busy_a), .rise1_cnt(r1_a), .rise2_cnt(r2_a), .both_cnt(bc_a),
        .res_valid(rv_a), .res_ready(res_ready)
    );
    comb_event_tracker #(.CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .Y1(Y1), .Y2(Y2), .start(start), .win_len(win_len),
        .clr(clr), .busy(busy_b), .rise1_cnt(r1_b), .rise2_cnt(r2_b), .both_cnt(bc_b),
        .res_valid(rv_b), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v, input int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    // reference: count events over the window samples, using the t0 value as the previous sample
    task automatic model(input bit t1, input bit t2);
        int e1 = 0, e2 = 0, eb = 0;
        bit p1 = t1, p2 = t2;
        foreach (q1[i]) begin
            if (q1[i] && !p1) e1++;
            if (q2[i] && !p2) e2++;
            if (q1[i] && q2[i]) eb++;
            p1 = q1[i];
            p2 = q2[i];
        end
        exp_a = {8'(sat(e1, 8)), 8'(sat(e2, 8)), 8'(sat(eb, 8))};
        exp_b = {2'(sat(e1, 2)), 2'(sat(e2, 2)), 2'(sat(eb, 2))};
    endtask

    task automatic fill_random(input int n);
        q1 = {};
        q2 = {};
        for (int i = 0; i < n; i++) begin
            q1.push_back(1'($urandom));
            q2.push_back(1'($urandom));
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_window(input int n, input bit t1, input bit t2, input bit noise);
        Y1 = t1;
        Y2 = t2;
        start = 1'b1;
        win_len = 8'(n);
        tick();
        start = 1'b0;
        model(t1, t2);
        n_checks++;
        if ({busy_a, rv_a, busy_b, rv_b} !== {1'b1, n == 0, 1'b1, n == 0}) begin
            n_fail++;
            $display("FAIL start_edge: got busy/valid a,b=%b expected %b", {busy_a, rv_a, busy_b, rv_b}, {1'b1, n == 0, 1'b1, n == 0});
        end
        for (int i = 0; i < n; i++) begin
            Y1 = q1[i];
            Y2 = q2[i];
            if (noise) begin
                start = 1'($urandom);
                win_len = 8'($urandom);
                res_ready = 1'($urandom);
            end
            tick();
            n_checks++;
            if ({busy_a, rv_a, busy_b, rv_b} !== {1'b1, i == n - 1, 1'b1, i == n - 1}) begin
                n_fail++;
                $display("FAIL window_edge%0d/%0d: got busy/valid a,b=%b expected %b", i + 1, n, {busy_a, rv_a, busy_b, rv_b}, {1'b1, i == n - 1, 1'b1, i == n - 1});
            end
        end
        start = 1'b0;
        res_ready = 1'b0;
        n_checks++;
        if ({r1_a, r2_a, bc_a} !== exp_a) begin
            n_fail++;
            $display("FAIL counts_w8 len=%0d: got %h expected %h", n, {r1_a, r2_a, bc_a}, exp_a);
        end
        n_checks++;
        if ({r1_b, r2_b, bc_b} !== exp_b) begin
            n_fail++;
            $display("FAIL counts_w2 len=%0d: got %b expected %b", n, {r1_b, r2_b, bc_b}, exp_b);
        end
    endtask

    task automatic finish_handshake(input int hold);
        for (int i = 0; i < hold; i++) begin
            start = 1'($urandom);
            Y1 = 1'($urandom);
            Y2 = 1'($urandom);
            tick();
            n_checks++;
            if ({busy_a, rv_a, r1_a, r2_a, bc_a, rv_b, r1_b, r2_b, bc_b} !== {2'b11, exp_a, 1'b1, exp_b}) begin
                n_fail++;
                $display("FAIL report_hold%0d: got %h expected %h", i, {busy_a, rv_a, r1_a, r2_a, bc_a, rv_b, r1_b, r2_b, bc_b}, {2'b11, exp_a, 1'b1, exp_b});
            end
        end
        res_ready = 1'b1;
        start = 1'b1;
        tick();
        res_ready = 1'b0;
        start = 1'b0;
        n_checks++;
        if ({busy_a, rv_a, r1_a, r2_a, bc_a, busy_b, rv_b, r1_b, r2_b, bc_b} !== {2'b00, exp_a, 2'b00, exp_b}) begin
            n_fail++;
            $display("FAIL handshake_done: got %h expected %h", {busy_a, rv_a, r1_a, r2_a, bc_a, busy_b, rv_b, r1_b, r2_b, bc_b}, {2'b00, exp_a, 2'b00, exp_b});
        end
        tick();
        n_checks++;
        if ({busy_a, rv_a, r1_a, r2_a, bc_a} !== {2'b00, exp_a}) begin
            n_fail++;
            $display("FAIL idle_after_handshake: got %h expected %h", {busy_a, rv_a, r1_a, r2_a, bc_a}, {2'b00, exp_a});
        end
    endtask

    task automatic test_reset;
        #1;
        n_checks++;
        if ({busy_a, rv_a, r1_a, r2_a, bc_a, busy_b, rv_b, r1_b, r2_b, bc_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected 0", {busy_a, rv_a, r1_a, r2_a, bc_a, busy_b, rv_b, r1_b, r2_b, bc_b});
        end
        #12 rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({busy_a, rv_a} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b expected 00", {busy_a, rv_a});
        end
    endtask

    task automatic test_basic;
        q1 = {1'b0, 1'b1, 1'b0, 1'b1};
        q2 = {1'b1, 1'b1, 1'b1, 1'b1};
        run_window(4, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({r1_a, r2_a, bc_a} !== {8'd2, 8'd1, 8'd2}) begin
            n_fail++;
            $display("FAIL basic_counts: got %h expected 020102", {r1_a, r2_a, bc_a});
        end
        finish_handshake(0);
    endtask

    task automatic test_saturation;
        q1 = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        q2 = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        run_window(8, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({r1_b, r2_b, bc_b} !== {2'd3, 2'd1, 2'd3}) begin
            n_fail++;
            $display("FAIL saturation_w2: got %b expected 110111", {r1_b, r2_b, bc_b});
        end
        finish_handshake(1);
    endtask

    task automatic test_handshake;
        fill_random(6);
        run_window(6, 1'b1, 1'b0, 1'b0);
        finish_handshake(5);
    endtask

    task automatic test_zero_and_ignored_start;
        q1 = {};
        q2 = {};
        run_window(0, 1'b1, 1'b1, 1'b0);
        finish_handshake(2);
        fill_random(9);
        run_window(9, 1'b0, 1'b1, 1'b1);
        finish_handshake(1);
    endtask

    task automatic test_clr;
        fill_random(6);
        Y1 = 1'b0;
        Y2 = 1'b0;
        start = 1'b1;
        win_len = 8'd6;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            Y1 = q1[i];
            Y2 = q2[i];
            clr = (i == 2);
            start = (i == 2);
            tick();
        end
        clr = 1'b0;
        start = 1'b0;
        n_checks++;
        if ({busy_a, rv_a, r1_a, r2_a, bc_a, busy_b, rv_b} !== '0) begin
            n_fail++;
            $display("FAIL clr_in_run: got %h expected 0", {busy_a, rv_a, r1_a, r2_a, bc_a, busy_b, rv_b});
        end
        tick();
        n_checks++;
        if ({busy_a, rv_a} !== 2'b00) begin
            n_fail++;
            $display("FAIL clr_stays_idle: got %b expected 00", {busy_a, rv_a});
        end
        clr = 1'b1;
        start = 1'b1;
        win_len = 8'd3;
        tick();
        clr = 1'b0;
        start = 1'b0;
        n_checks++;
        if ({busy_a, rv_a} !== 2'b00) begin
            n_fail++;
            $display("FAIL clr_over_start: got %b expected 00", {busy_a, rv_a});
        end
        q1 = {1'b1, 1'b1};
        q2 = {1'b1, 1'b1};
        run_window(2, 1'b0, 1'b0, 1'b0);
        clr = 1'b1;
        res_ready = 1'b1;
        tick();
        clr = 1'b0;
        res_ready = 1'b0;
        n_checks++;
        if ({busy_a, rv_a, r1_a, r2_a, bc_a} !== '0) begin
            n_fail++;
            $display("FAIL clr_over_handshake: got %h expected 0", {busy_a, rv_a, r1_a, r2_a, bc_a});
        end
    endtask

    task automatic test_async_reset;
        fill_random(3);
        run_window(3, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy_a, rv_a, r1_a, r2_a, bc_a, busy_b, rv_b, r1_b, r2_b, bc_b} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_report: got %h expected 0", {busy_a, rv_a, r1_a, r2_a, bc_a, busy_b, rv_b, r1_b, r2_b, bc_b});
        end
        rst_n = 1'b1;
        fill_random(10);
        Y1 = 1'b1;
        start = 1'b1;
        win_len = 8'd10;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            Y1 = q1[i];
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy_a, rv_a, r1_a, r2_a, bc_a} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_run: got %h expected 0", {busy_a, rv_a, r1_a, r2_a, bc_a});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        n_checks++;
        if ({busy_a, rv_a} !== 2'b00) begin
            n_fail++;
            $display("FAIL wait_new_start: got %b expected 00", {busy_a, rv_a});
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 12; k++) begin
            int n = (k == 11) ? 255 : int'($urandom_range(1, 40));
            fill_random(n);
            run_window(n, 1'($urandom), 1'($urandom), 1'b1);
            finish_handshake(int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_handshake();
        test_zero_and_ignored_start();
        test_clr();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
